// File: rtl/burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : burst_mem_slave
// Brief    : Wait-state burst memory slave, single/INCR beats, byte strobes.
//            Optional macro MEM_SLAVE_RANGE_CHECK_EN enables out-of-range trap.
// Revision : 1.0 - initial release
// ============================================================================
module burst_mem_slave #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int WAIT_CYCLES  = 2,
    parameter int BURST_LENGTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ADDR,
    input  logic [1:0]  BURST,
    input  logic        REQ,
    input  logic        WRB,
    input  logic [31:0] WDATA,
    input  logic [3:0]  BSTROBE,
    output logic [31:0] RDATA,
    output logic        ACK,
    output logic        STALL,
    output logic        err
);

    localparam int              c_AW        = $clog2(DEPTH_WORDS);
    localparam int              c_BW        = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(BURST_LENGTH - 1);
    localparam logic [3:0]      c_WAIT      = 4'(WAIT_CYCLES);
    localparam logic [31:0]     c_BAD_DATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t          r_state_q;
    logic            r_incr_q;
    logic [c_BW-1:0] r_beat_q;
    logic [3:0]      r_wait_q;
    logic            r_ack_q;
    logic [31:0]     r_rdata_q;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_stall;
    logic            w_accept;
    logic            w_last;
    logic            w_oor;
    logic [c_AW-1:0] w_idx;
    logic            w_unused_lo;

    assign w_idx       = ADDR[c_AW+1:2];
    assign w_unused_lo = ^ADDR[1:0];

    always_comb begin
        w_stall  = (r_state_q == S_WAIT) || (r_state_q == S_IDLE && REQ && c_WAIT != 4'd0);
        // Reset gates acceptance so an aborted beat never reaches the array.
        w_accept = !reset && REQ && !w_stall &&
                   (r_state_q == S_ACTIVE || (r_state_q == S_IDLE && c_WAIT == 4'd0));
        w_last   = 1'b0;
        case (r_state_q)
            S_IDLE:   w_last = (BURST != 2'b01) || (c_LAST_BEAT == '0);
            S_ACTIVE: w_last = !r_incr_q || (r_beat_q == c_LAST_BEAT);
            default:  w_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_incr_q  <= 1'b0;
            r_beat_q  <= '0;
            r_wait_q  <= 4'd0;
            r_ack_q   <= 1'b0;
            r_rdata_q <= 32'd0;
        end else begin
            r_ack_q <= w_accept;
            if (w_accept && !WRB) begin
                r_rdata_q <= w_oor ? c_BAD_DATA : r_mem[w_idx];
            end
            case (r_state_q)
                S_IDLE: begin
                    if (REQ) begin
                        r_incr_q <= (BURST == 2'b01);
                        r_beat_q <= '0;
                        if (c_WAIT != 4'd0) begin
                            r_wait_q  <= c_WAIT;
                            r_state_q <= S_WAIT;
                        end else begin
                            r_beat_q  <= w_last ? '0 : c_BW'(1);
                            r_state_q <= w_last ? S_DRAIN : S_ACTIVE;
                        end
                    end
                end
                S_WAIT: begin
                    // Leave once the decremented count reaches 1.
                    r_wait_q <= r_wait_q - 4'd1;
                    if (r_wait_q <= 4'd2) begin
                        r_state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_beat_q  <= '0;
                            r_state_q <= S_DRAIN;
                        end else begin
                            r_beat_q <= r_beat_q + c_BW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!REQ) begin
                        r_state_q <= S_IDLE;
                    end
                end
                default: r_state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && WRB && !w_oor) begin
            for (int n = 0; n < 4; n++) begin
                if (BSTROBE[n]) begin
                    r_mem[w_idx][8*n +: 8] <= WDATA[8*n +: 8];
                end
            end
        end
    end

`ifdef MEM_SLAVE_RANGE_CHECK_EN
    logic r_err_q;

    assign w_oor = |ADDR[31:c_AW+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_q <= 1'b0;
        end else if (w_accept && w_oor) begin
            r_err_q <= 1'b1;
        end
    end

    assign err = r_err_q;
`else
    logic w_unused_hi;

    assign w_oor       = 1'b0;
    assign w_unused_hi = ^ADDR[31:c_AW+2];
    assign err         = 1'b0;
`endif

    assign STALL = w_stall;
    assign ACK   = r_ack_q;
    assign RDATA = r_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_mem_slave
// Brief    : Directed self-checking bench for burst_mem_slave (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_mem_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ADDR;
    logic [1:0]  BURST;
    logic        REQ;
    logic        WRB;
    logic [31:0] WDATA;
    logic [3:0]  BSTROBE;
    logic [31:0] RDATA;
    logic        ACK;
    logic        STALL;
    logic        err;

    int          checks = 0;
    int          errors = 0;

    int          b_acks;
    logic [31:0] b_rd [8];
    logic        b_tail;
    logic        s_ack;
    logic [31:0] s_rd;

    burst_mem_slave #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2),
        .BURST_LENGTH(8)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .ADDR   (ADDR),
        .BURST  (BURST),
        .REQ    (REQ),
        .WRB    (WRB),
        .WDATA  (WDATA),
        .BSTROBE(BSTROBE),
        .RDATA  (RDATA),
        .ACK    (ACK),
        .STALL  (STALL),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    // One transaction with REQ dropped as soon as the single beat is acknowledged.
    task automatic single(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] btype);
        int guard;
        @(negedge clk);
        REQ = 1'b1; BURST = btype; WRB = wr; ADDR = addr; WDATA = data; BSTROBE = strb;
        guard = 0;
        #1;
        while (STALL !== 1'b0 && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        @(negedge clk);
        s_ack = ACK;
        s_rd  = RDATA;
        REQ   = 1'b0;
        @(negedge clk);
    endtask

    // Eight-beat INCR burst; beat i uses base+4i and wbase+i.
    task automatic burst(input logic wr, input logic [31:0] base, input logic [31:0] wbase);
        int guard;
        @(negedge clk);
        REQ = 1'b1; BURST = 2'b01; WRB = wr; ADDR = base; WDATA = wbase; BSTROBE = 4'hF;
        guard = 0;
        #1;
        while (STALL !== 1'b0 && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        b_acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ACK === 1'b1) b_acks++;
            b_rd[i] = RDATA;
            if (i < 7) begin
                ADDR  = base + 32'(4 * (i + 1));
                WDATA = wbase + 32'(i + 1);
            end else begin
                REQ = 1'b0;
            end
        end
        @(negedge clk);
        b_tail = ACK;
    endtask

    task automatic test_reset();
        reset = 1'b1; REQ = 1'b0; BURST = 2'b00; WRB = 1'b0;
        ADDR = 32'd0; WDATA = 32'd0; BSTROBE = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ACK); end
        checks++; if (RDATA !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", RDATA); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b want 0", STALL); end
        REQ = 1'b1;
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL reset_stall_req got %b want 1", STALL); end
        REQ = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        single(1'b1, 32'h10, 32'h1234_5678, 4'hF, 2'b00);
        @(negedge clk);
        REQ = 1'b1; BURST = 2'b00; WRB = 1'b0; ADDR = 32'h10;
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL sr_stall0 got %b want 1", STALL); end
        @(negedge clk); #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL sr_stall1 got %b want 1", STALL); end
        @(negedge clk); #1;
        checks++; if (STALL !== 1'b0 || ACK !== 1'b0) begin
            errors++; $display("FAIL sr_active stall=%b ack=%b want 0 0", STALL, ACK);
        end
        @(negedge clk); #1;
        checks++; if (ACK !== 1'b1 || RDATA !== 32'h1234_5678) begin
            errors++; $display("FAIL sr_data ack=%b rdata=%h want 1 12345678", ACK, RDATA);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++; if (ACK !== 1'b0 || STALL !== 1'b0) begin
                errors++; $display("FAIL sr_drain%0d ack=%b stall=%b want 0 0", i, ACK, STALL);
            end
        end
        REQ = 1'b0;
        @(negedge clk);
        REQ = 1'b1;
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL sr_back_idle stall=%b want 1", STALL); end
        REQ = 1'b0;
    endtask

    task automatic test_incr_burst();
        burst(1'b1, 32'h20, 32'd0);
        checks++; if (b_acks != 8) begin errors++; $display("FAIL incr_wr_acks got %0d want 8", b_acks); end
        checks++; if (b_tail !== 1'b0) begin errors++; $display("FAIL incr_wr_tail got %b want 0", b_tail); end
        burst(1'b0, 32'h20, 32'd0);
        checks++; if (b_acks != 8) begin errors++; $display("FAIL incr_rd_acks got %0d want 8", b_acks); end
        checks++; if (b_tail !== 1'b0) begin errors++; $display("FAIL incr_rd_tail got %b want 0", b_tail); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (b_rd[i] !== 32'(i)) begin
                errors++; $display("FAIL incr_rd_data%0d got %h want %h", i, b_rd[i], 32'(i));
            end
        end
    endtask

    task automatic test_strobe();
        single(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 2'b00);
        single(1'b1, 32'h0, 32'h0000_0000, 4'b0101, 2'b10);
        checks++; if (s_ack !== 1'b1) begin errors++; $display("FAIL strobe_wr_ack got %b want 1", s_ack); end
        single(1'b0, 32'h0, 32'h0, 4'h0, 2'b11);
        checks++; if (s_ack !== 1'b1) begin errors++; $display("FAIL strobe_rd_ack got %b want 1", s_ack); end
        checks++; if (s_rd !== 32'hFF00_FF00) begin
            errors++; $display("FAIL strobe_data got %h want ff00ff00", s_rd);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int acks;
        logic [31:0] exp;
        burst(1'b1, 32'h80, 32'hA0);
        @(negedge clk);
        REQ = 1'b1; BURST = 2'b01; WRB = 1'b1; ADDR = 32'h80; WDATA = 32'h50; BSTROBE = 4'hF;
        guard = 0;
        #1;
        while (STALL !== 1'b0 && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ACK === 1'b1) acks++;
            ADDR  = 32'h80 + 32'(4 * (i + 1));
            WDATA = 32'h50 + 32'(i + 1);
        end
        checks++; if (acks != 3) begin errors++; $display("FAIL rm_acks got %0d want 3", acks); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ACK !== 1'b0) begin errors++; $display("FAIL rm_ack_after_reset got %b want 0", ACK); end
        checks++; if (RDATA !== 32'd0) begin errors++; $display("FAIL rm_rdata got %h want 0", RDATA); end
        reset = 1'b0;
        #1;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL rm_idle stall=%b want 1", STALL); end
        REQ = 1'b0;
        burst(1'b0, 32'h80, 32'd0);
        for (int i = 0; i < 8; i++) begin
            exp = (i < 3) ? 32'h50 + 32'(i) : 32'hA0 + 32'(i);
            checks++; if (b_rd[i] !== exp) begin
                errors++; $display("FAIL rm_word%0d got %h want %h", i, b_rd[i], exp);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] exp_d;
        logic        exp_e;
`ifdef MEM_SLAVE_RANGE_CHECK_EN
        exp_d = 32'hDEAD_BEEF;
        exp_e = 1'b1;
`else
        exp_d = 32'hFF00_FF00;
        exp_e = 1'b0;
`endif
        single(1'b0, 32'h8000_0000, 32'h0, 4'h0, 2'b00);
        checks++; if (s_ack !== 1'b1) begin errors++; $display("FAIL range_ack got %b want 1", s_ack); end
        checks++; if (s_rd !== exp_d) begin errors++; $display("FAIL range_data got %h want %h", s_rd, exp_d); end
        @(negedge clk);
        checks++; if (err !== exp_e) begin errors++; $display("FAIL range_err got %b want %b", err, exp_e); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_incr_burst();
        test_strobe();
        test_reset_mid();
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_mem_slave.md
BURST_MEM_SLAVE -- requirements
Module: burst_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning STALL cycles inserted before the first beat of each transaction (0..15).
REQ-003 SHALL have parameter BURST_LENGTH, default 8, meaning beats per INCR burst.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 ADDR  input  32  byte address; word index = ADDR[log2(DEPTH_WORDS)+1:2].
REQ-007 BURST  input  2  00 single, 01 INCR; 10 and 11 are treated as single.
REQ-008 REQ  input  1  transfer request.
REQ-009 WRB  input  1  1 write beat, 0 read beat.
REQ-010 WDATA  input  32  write data.
REQ-011 BSTROBE  input  4  byte-lane enables for writes, bit n maps to WDATA[8n+7:8n].
REQ-012 RDATA  output  32  read data.
REQ-013 ACK  output  1  beat-complete strobe.
REQ-014 STALL  output  1  slave not accepting a beat this cycle.
REQ-015 err  output  1  sticky out-of-range flag (see Configuration).

Function
REQ-016 A beat SHALL be accepted in any cycle where REQ=1, STALL=0 and the state is WAIT_DONE-qualified (state ACTIVE, or IDLE with WAIT_CYCLES=0).
REQ-017 The FSM SHALL have states IDLE, WAIT, ACTIVE, DRAIN.
REQ-018 IDLE: on REQ=1, latch BURST into a burst type register; go to WAIT if WAIT_CYCLES>0, else accept beat 0 in the same cycle and go to ACTIVE (or DRAIN if the type is single).
REQ-019 WAIT: a counter loaded with WAIT_CYCLES at IDLE exit decrements each cycle; go to ACTIVE when it reaches 1.
REQ-020 STALL SHALL be combinational: 1 in WAIT, 1 in IDLE when REQ=1 and WAIT_CYCLES>0, otherwise 0.
REQ-021 ACTIVE: each accepted beat increments a beat counter; after beat BURST_LENGTH-1 (INCR) or beat 0 (single), go to DRAIN.
REQ-022 ACTIVE with REQ=0: hold state and counter, no accept, no ACK.
REQ-023 DRAIN: no accepts and no ACK; return to IDLE on the first cycle with REQ=0.
REQ-024 Read beat: RDATA SHALL be loaded with mem[word index] and ACK=1 in the cycle after acceptance (1-cycle latency); ACK SHALL be 0 in all other cycles.
REQ-025 Write beat: enabled byte lanes SHALL be written at the accept edge; ACK=1 the next cycle; RDATA holds its previous value.
REQ-026 A read in the cycle after a write to the same word SHALL return the written data.
REQ-027 The slave SHALL use ADDR as supplied each beat and SHALL NOT generate addresses internally.
REQ-028 Back-to-back accepts SHALL produce one ACK per cycle with no gaps.

Reset
REQ-029 On reset: state IDLE, beat and wait counters 0, ACK=0, RDATA=0, err=0; STALL follows REQ-020 from state IDLE.
REQ-030 Reset mid-transaction SHALL abort it: no ACK in the following cycle, and beats written before reset are retained.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro MEM_SLAVE_RANGE_CHECK_EN.
- Defined: a beat with ADDR[31:log2(DEPTH_WORDS)+2] nonzero is still ACKed; a read returns 32'hDEAD_BEEF, a write is discarded, and err is set until reset.
- Not defined: the upper address bits are ignored (index wraps modulo DEPTH_WORDS) and err is tied to 0.

Verification
REQ-033 Single read, WAIT_CYCLES=2, mem[4]=32'h1234_5678, REQ=1, BURST=00, ADDR=0x10 -> STALL high 2 cycles, then ACK one cycle with RDATA=32'h1234_5678, then DRAIN until REQ=0.
REQ-034 INCR write of 8 beats from ADDR 0x20 with WDATA=beat index, BSTROBE=4'hF, then INCR read of the same range -> 8 consecutive ACKs per burst; read data 0..7 in order.
REQ-035 Byte strobe: mem[0]=32'hFFFF_FFFF, write WDATA=32'h0000_0000 with BSTROBE=4'b0101, then read -> RDATA=32'hFF00_FF00.
REQ-036 Reset asserted after the 3rd accepted beat of an INCR write -> ACK=0 on the next cycle; state IDLE; words 0-2 written, words 3-7 unchanged.
REQ-037 REQ held high 2 cycles after the last beat -> no extra ACK, no new transaction; IDLE after REQ falls.
REQ-038 With MEM_SLAVE_RANGE_CHECK_EN, read ADDR=0x8000_0000 -> ACK, RDATA=32'hDEAD_BEEF, err=1 sticky; without the macro, the same read returns mem[0] and err=0.
